// File: rtl/ps2_key_decoder_pkg.sv
// ps2_dec_pkg: shared types and constants for the PS/2 key decoder.
//   rx_state_t    : receive FSM states
//   PS2_PFX_EXT   : extended-key prefix byte (E0)
//   PS2_PFX_REL   : key-release prefix byte (F0)
//   ps2_key_t     : 11-bit key event word {toggle, pressed, ext, code}
//   odd_parity_ok : true when data byte plus parity bit carry an odd number of ones
package ps2_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer followed by a debounce filter for one
// asynchronous PS/2 line. The filtered level only changes after FILTER_LEN
// consecutive synchronized samples disagree with it.
// Ports:
//   clk_sys : system clock
//   reset   : synchronous active-high reset (line idles high)
//   line_i  : raw asynchronous pin
//   line_o  : synchronized, filtered level
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      // Count disagreeing samples; any agreeing sample restarts the run.
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receives PS/2 keyboard frames and rebuilds the 11-bit key
// event word {toggle, pressed, extended, code}. E0/F0 prefix bytes are held as
// flags and attached to the next non-prefix byte; any error drops them.
// Optional feature macro: PS2_DEC_ERRCNT_EN adds the err_count port.
// Ports:
//   clk_sys       : system clock (only clock)
//   reset         : synchronous active-high reset
//   ps2_clk       : raw PS/2 clock pin (async)
//   ps2_dat       : raw PS/2 data pin (async)
//   ps2_key       : key event word, bit 10 toggles on every new event
//   rx_byte       : last byte that passed all frame checks
//   rx_byte_valid : one-cycle pulse when rx_byte updates
//   rx_err        : one-cycle pulse on start/parity/stop/timeout error
//   err_count     : saturating error counter (PS2_DEC_ERRCNT_EN only)
//   dbg_state     : current receive FSM state
//
// Handshake: rx_byte_valid and rx_err are single-cycle strobes with no ready;
// rx_byte and ps2_key are stable from the strobe until the next event.
module ps2_key_decoder
  import ps2_dec_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        rx_err,
`ifdef PS2_DEC_ERRCNT_EN
  output logic [7:0]  err_count,
`endif
  output logic [1:0]  dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  logic clk_f;
  logic dat_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys(clk_sys), .reset(reset), .line_i(ps2_clk), .line_o(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_sys(clk_sys), .reset(reset), .line_i(ps2_dat), .line_o(dat_f)
  );

  rx_state_t        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             clk_prev_q;
  ps2_key_t         key_q, key_d;
  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             valid_q;
  logic             err_q;

  logic fall;
  logic accept;
  logic err;

  assign fall = clk_prev_q & ~clk_f;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    accept    = 1'b0;
    err       = 1'b0;
    // A fall always clears the counter, even on the cycle it would expire.
    if (fall)                 tmo_d = '0;
    else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
    else                      tmo_d = tmo_q + TMO_W'(1);

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_f) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_f;
          state_d = STOP;
        end
        default: begin
          if (dat_f && odd_parity_ok(shift_q, par_q)) accept = 1'b1;
          else                                        err    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_MAX) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  always_comb begin
    key_d     = key_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    rx_byte_d = rx_byte_q;
    if (accept) begin
      rx_byte_d = shift_q;
      if (shift_q == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_PFX_REL) begin
        rel_d = 1'b1;
      end else begin
        key_d = {~key_q.toggle, ~rel_q, ext_q, shift_q};
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
    if (err) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      clk_prev_q <= 1'b1;
      key_q      <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      rx_byte_q  <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      clk_prev_q <= clk_f;
      key_q      <= key_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      rx_byte_q  <= rx_byte_d;
      valid_q    <= accept;
      err_q      <= err;
    end
  end

`ifdef PS2_DEC_ERRCNT_EN
  logic [7:0] errcnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset)                          errcnt_q <= 8'd0;
    else if (err && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
  end

  assign err_count = errcnt_q;
`endif

  assign ps2_key       = key_q;
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = valid_q;
  assign rx_err        = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed bench for ps2_key_decoder. Drives PS/2 frames
// on the raw pins and checks the key word, byte strobes and error strobes.
module tb_ps2_key_decoder;

  localparam int HALF = 15;  // PS/2 half bit period in clk_sys cycles

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_err;
  logic [1:0]  dbg_state;
`ifdef PS2_DEC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  ps2_key_decoder dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .ps2_key(ps2_key),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_err(rx_err),
`ifdef PS2_DEC_ERRCNT_EN
    .err_count(err_count),
`endif
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int ecnt  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  // strobe monitor
  always @(negedge clk_sys) begin
    if (rx_byte_valid) begin
      vcnt++;
      obs_q.push_back(rx_byte);
    end
    if (rx_err) ecnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    if (!bad_par) exp_q.push_back(b);
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic check_bytes();
    check("byte_count", 16'(obs_q.size()), 16'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check("byte_value", {8'h00, obs_q.pop_front()}, {8'h00, exp_q.pop_front()});
    obs_q.delete();
    exp_q.delete();
  endtask

  int v0, e0, cycles;
  logic seen;

  initial begin
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    reset   = 1'b1;
    repeat (4) @(posedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // reset state
    check("rst_key", {5'd0, ps2_key}, 16'h0000);
    check("rst_byte", {8'd0, rx_byte}, 16'h0000);
    check("rst_valid", {15'd0, rx_byte_valid}, 16'h0000);
    check("rst_err", {15'd0, rx_err}, 16'h0000);
    check("rst_state", {14'd0, dbg_state}, 16'h0000);

    // make 1C: toggle=1, pressed=1, ext=0
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b0);
    check("t1_key", {5'd0, ps2_key}, 16'h061C);
    check("t1_byte", {8'd0, rx_byte}, 16'h001C);
    check("t1_vcnt", 16'(vcnt - v0), 16'd1);
    check("t1_ecnt", 16'(ecnt - e0), 16'd0);
    check("t1_state", {14'd0, dbg_state}, 16'h0000);

    // break F0 1C: toggle=0, pressed=0
    v0 = vcnt;
    send_frame(8'hF0, 1'b0);
    check("t2_f0_key", {5'd0, ps2_key}, 16'h061C);
    send_frame(8'h1C, 1'b0);
    check("t2_key", {5'd0, ps2_key}, 16'h001C);
    check("t2_vcnt", 16'(vcnt - v0), 16'd2);

    // extended make E0 75, then extended break E0 F0 75
    send_frame(8'hE0, 1'b0);
    check("t3_e0_key", {5'd0, ps2_key}, 16'h001C);
    check("t3_e0_byte", {8'd0, rx_byte}, 16'h00E0);
    send_frame(8'h75, 1'b0);
    check("t3_make", {5'd0, ps2_key}, 16'h0775);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("t3_break", {5'd0, ps2_key}, 16'h0175);

    // bad parity: error, no byte, key unchanged
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b1);
    check("t4_ecnt", 16'(ecnt - e0), 16'd1);
    check("t4_vcnt", 16'(vcnt - v0), 16'd0);
    check("t4_key", {5'd0, ps2_key}, 16'h0175);
    send_frame(8'h1C, 1'b0);
    check("t4_recover", {5'd0, ps2_key}, 16'h061C);
    // an error between E0 and the code drops the prefix
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0);
    check("t4_pfx_drop", {5'd0, ps2_key}, 16'h021C);
    check_bytes();

    // timeout: start bit + 4 data bits of 2A, then stall
    e0 = ecnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 60000) begin
      @(posedge clk_sys);
      #1;
      cycles++;
      if (rx_err) seen = 1'b1;
    end
    check("t5_err_seen", {15'd0, seen}, 16'd1);
    check("t5_tmo_window", {15'd0, (cycles >= 49994 && cycles <= 49998)}, 16'd1);
    @(negedge clk_sys);
    check("t5_state", {14'd0, dbg_state}, 16'h0000);
    check("t5_key", {5'd0, ps2_key}, 16'h021C);
    send_frame(8'h2A, 1'b0);
    check("t5_after", {5'd0, ps2_key}, 16'h062A);
    check("t5_ecnt", 16'(ecnt - e0), 16'd1);

    // short low glitch on ps2_clk while idle is ignored
    e0 = ecnt;
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    check("t6_glitch_state", {14'd0, dbg_state}, 16'h0000);
    check("t6_glitch_err", 16'(ecnt - e0), 16'd0);
    check("t6_glitch_key", {5'd0, ps2_key}, 16'h062A);

    // reset mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("t6_rst_key", {5'd0, ps2_key}, 16'h0000);
    check("t6_rst_byte", {8'd0, rx_byte}, 16'h0000);
    check("t6_rst_state", {14'd0, dbg_state}, 16'h0000);
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    check("t6_rst_noerr", 16'(ecnt - e0), 16'd0);
    send_frame(8'h1C, 1'b0);
    check("t6_toggle_restart", {5'd0, ps2_key}, 16'h061C);
    check_bytes();

`ifdef PS2_DEC_ERRCNT_EN
    // data high at a clock fall in idle is a start-bit error
    check("t7_cnt0", {8'd0, err_count}, 16'h0000);
    send_bit(1'b1);
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    check("t7_cnt1", {8'd0, err_count}, 16'h0001);
    for (int i = 0; i < 299; i++) send_bit(1'b1);
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    check("t7_sat", {8'd0, err_count}, 16'h00FF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
